// File: rtl/wb_write_queue_pkg.sv
// Shared regfile package for the write-back queue.
// Provides the architectural register count, register width, the derived
// register-address width, and a one-hot decoder for per-register write enables.
package wb_write_queue_pkg;

  localparam int unsigned RF_NREG  = 32;
  localparam int unsigned RF_WIDTH = 32;
  localparam int unsigned RF_AW    = $clog2(RF_NREG);

  // One-hot decode of a register index into a per-register enable vector.
  function automatic logic [RF_NREG-1:0] rf_onehot(input logic [RF_AW-1:0] idx);
    logic [RF_NREG-1:0] vec;
    vec      = {RF_NREG{1'b0}};
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/wbq_fwd_match.sv
// Youngest-match search for register forwarding.
// Candidates are ordered by age: index 0 is the oldest, index NC-1 the youngest.
// Ports:
//   cand_vld_i  - per-candidate valid
//   cand_addr_i - per-candidate destination register index
//   cand_data_i - per-candidate data
//   rd_addr_i   - read address being checked
//   hit_o       - some valid candidate targets rd_addr_i (never for register 0)
//   data_o      - data of the youngest matching candidate, 0 when no hit
module wbq_fwd_match #(
  parameter int unsigned NC    = 5,
  parameter int unsigned AW    = 5,
  parameter int unsigned WIDTH = 32
) (
  input  logic [NC-1:0]            cand_vld_i,
  input  logic [NC-1:0][AW-1:0]    cand_addr_i,
  input  logic [NC-1:0][WIDTH-1:0] cand_data_i,
  input  logic [AW-1:0]            rd_addr_i,
  output logic                     hit_o,
  output logic [WIDTH-1:0]         data_o
);

  logic             hit_s;
  logic [WIDTH-1:0] data_s;
  logic             match_s;

  // Scan oldest to youngest so a later (younger) match overrides an earlier one.
  always_comb begin
    hit_s   = 1'b0;
    data_s  = {WIDTH{1'b0}};
    match_s = 1'b0;
    for (int i = 0; i < NC; i++) begin
      match_s = cand_vld_i[i] && (cand_addr_i[i] == rd_addr_i) && (rd_addr_i != {AW{1'b0}});
      hit_s   = hit_s | match_s;
      data_s  = match_s ? cand_data_i[i] : data_s;
    end
  end

  assign hit_o  = hit_s;
  assign data_o = data_s;

endmodule

// File: rtl/wb_write_queue.sv
// Write-back queue in front of a negative-edge-capturing register array.
// Requests are buffered in a small FIFO and drained one per cycle as a
// registered one-hot write enable plus broadcast data. Pending and in-flight
// entries are searched for read-port forwarding.
// Ports:
//   clk, rst               - clock, asynchronous active-high reset
//   in_valid/in_addr/in_data, in_ready - write-back request handshake
//   drain_stall            - hold the head entry (no write this cycle)
//   wr_en, wr_data         - registered write to the register array
//   rd_addr_a/b            - read addresses checked for forwarding
//   fwd_hit_a/b, fwd_data_a/b - forwarding results (youngest pending write)
//   level                  - number of queued entries
module wb_write_queue
  import wb_write_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned NREG  = RF_NREG,
  parameter int unsigned WIDTH = RF_WIDTH,
  localparam int unsigned AW   = $clog2(NREG),
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned LW   = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [AW-1:0]    in_addr,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             drain_stall,
  output logic [NREG-1:0]  wr_en,
  output logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic             fwd_hit_a,
  output logic             fwd_hit_b,
  output logic [WIDTH-1:0] fwd_data_a,
  output logic [WIDTH-1:0] fwd_data_b,
  output logic [LW-1:0]    level
);

  localparam int unsigned NC = DEPTH + 1;

  // Flat storage array
  logic [AW-1:0]    addr_q [DEPTH];
  logic [WIDTH-1:0] data_q [DEPTH];

  logic [PW-1:0]    head_q,     head_d;
  logic [PW-1:0]    tail_q,     tail_d;
  logic [LW-1:0]    level_q,    level_d;
  logic [NREG-1:0]  wr_en_q,    wr_en_d;
  logic [WIDTH-1:0] wr_data_q,  wr_data_d;
  // Address and valid of the entry currently on wr_en/wr_data (still forwardable
  // until the register array captures it on the falling edge).
  logic [AW-1:0]    out_addr_q, out_addr_d;
  logic             out_vld_q,  out_vld_d;

  logic in_ready_s;
  logic push_s;
  logic pop_s;

  logic [NC-1:0]            cand_vld_s;
  logic [NC-1:0][AW-1:0]    cand_addr_s;
  logic [NC-1:0][WIDTH-1:0] cand_data_s;

  // A full queue refuses even if it pops this cycle; register 0 requests are
  // acknowledged but dropped.
  assign in_ready_s = (level_q < LW'(DEPTH));
  assign push_s     = in_valid && in_ready_s && (in_addr != {AW{1'b0}});
  assign pop_s      = (level_q != {LW{1'b0}}) && !drain_stall;

  // Next-state for pointers, occupancy and the registered write port.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    level_d    = level_q;
    wr_en_d    = {NREG{1'b0}};
    wr_data_d  = wr_data_q;
    out_addr_d = out_addr_q;
    out_vld_d  = 1'b0;
    if (pop_s) begin
      head_d     = head_q + PW'(1);
      wr_en_d    = rf_onehot(addr_q[head_q]);
      wr_data_d  = data_q[head_q];
      out_addr_d = addr_q[head_q];
      out_vld_d  = 1'b1;
    end else begin
      head_d     = head_q;
    end
    if (push_s) begin
      tail_d = tail_q + PW'(1);
    end else begin
      tail_d = tail_q;
    end
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Control and write-port registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= {PW{1'b0}};
      tail_q     <= {PW{1'b0}};
      level_q    <= {LW{1'b0}};
      wr_en_q    <= {NREG{1'b0}};
      wr_data_q  <= {WIDTH{1'b0}};
      out_addr_q <= {AW{1'b0}};
      out_vld_q  <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      level_q    <= level_d;
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
      out_addr_q <= out_addr_d;
      out_vld_q  <= out_vld_d;
    end
  end

  // Entry storage: the tail slot is written on an accepted push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= {AW{1'b0}};
        data_q[i] <= {WIDTH{1'b0}};
      end
    end else if (push_s) begin
      addr_q[tail_q] <= in_addr;
      data_q[tail_q] <= in_data;
    end
  end

  // Build the age-ordered candidate list: slot 0 is the in-flight write
  // (oldest), slots 1..DEPTH are queue entries from head to tail.
  always_comb begin
    cand_vld_s     = {NC{1'b0}};
    cand_addr_s    = '0;
    cand_data_s    = '0;
    cand_vld_s[0]  = out_vld_q;
    cand_addr_s[0] = out_addr_q;
    cand_data_s[0] = wr_data_q;
    for (int i = 0; i < DEPTH; i++) begin
      cand_vld_s[i+1]  = (LW'(i) < level_q);
      cand_addr_s[i+1] = addr_q[head_q + PW'(i)];
      cand_data_s[i+1] = data_q[head_q + PW'(i)];
    end
  end

  wbq_fwd_match #(.NC(NC), .AW(AW), .WIDTH(WIDTH)) u_fwd_a (
    .cand_vld_i  (cand_vld_s),
    .cand_addr_i (cand_addr_s),
    .cand_data_i (cand_data_s),
    .rd_addr_i   (rd_addr_a),
    .hit_o       (fwd_hit_a),
    .data_o      (fwd_data_a)
  );

  wbq_fwd_match #(.NC(NC), .AW(AW), .WIDTH(WIDTH)) u_fwd_b (
    .cand_vld_i  (cand_vld_s),
    .cand_addr_i (cand_addr_s),
    .cand_data_i (cand_data_s),
    .rd_addr_i   (rd_addr_b),
    .hit_o       (fwd_hit_b),
    .data_o      (fwd_data_b)
  );

  assign in_ready = in_ready_s;
  assign wr_en    = wr_en_q;
  assign wr_data  = wr_data_q;
  assign level    = level_q;

endmodule

// File: tb/tb_wb_write_queue.sv
// Self-checking bench for wb_write_queue: a queue-based reference model
// predicts level, in_ready, forwarding and write timing; a scoreboard of
// accepted requests is compared by a monitor whenever a write appears.
module tb_wb_write_queue;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [4:0]  in_addr;
  logic [31:0] in_data;
  logic        in_ready;
  logic        drain_stall;
  logic [31:0] wr_en;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr_a;
  logic [4:0]  rd_addr_b;
  logic        fwd_hit_a;
  logic        fwd_hit_b;
  logic [31:0] fwd_data_a;
  logic [31:0] fwd_data_b;
  logic [2:0]  level;

  int tests;
  int fails;

  ent_t mq[$];     // model: pending entries, oldest first
  ent_t sb_q[$];   // scoreboard: accepted writes awaiting the DUT
  logic fl_v;      // model: an entry is on the write port
  ent_t fl;

  wb_write_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .drain_stall(drain_stall),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .rd_addr_a  (rd_addr_a),
    .rd_addr_b  (rd_addr_b),
    .fwd_hit_a  (fwd_hit_a),
    .fwd_hit_b  (fwd_hit_b),
    .fwd_data_a (fwd_data_a),
    .fwd_data_b (fwd_data_b),
    .level      (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Youngest pending write to ra; the write-port entry is the oldest candidate.
  function automatic void model_fwd(input logic [4:0] ra, output logic h, output logic [31:0] d);
    h = 1'b0;
    d = 32'h0;
    if (ra != 5'd0) begin
      for (int i = int'(mq.size()) - 1; i >= 0; i--) begin
        if (!h && mq[i].a == ra) begin
          h = 1'b1;
          d = mq[i].d;
        end
      end
      if (!h && fl_v && fl.a == ra) begin
        h = 1'b1;
        d = fl.d;
      end
    end
  endfunction

  // One clock cycle, entered and left at a falling edge.
  task automatic step(input logic v, input logic [4:0] a, input logic [31:0] d,
                      input logic st, input logic [4:0] ra, input logic [4:0] rb);
    logic        acc;
    logic        pop;
    logic        eh;
    logic [31:0] ed;
    ent_t        e;
    in_valid    = v;
    in_addr     = a;
    in_data     = d;
    drain_stall = st;
    rd_addr_a   = ra;
    rd_addr_b   = rb;
    #1;
    chk("level", 64'(level), 64'(mq.size()));
    chk("in_ready", 64'(in_ready), 64'(mq.size() < DEPTH));
    model_fwd(ra, eh, ed);
    chk("fwd_hit_a", 64'(fwd_hit_a), 64'(eh));
    chk("fwd_data_a", 64'(fwd_data_a), 64'(ed));
    model_fwd(rb, eh, ed);
    chk("fwd_hit_b", 64'(fwd_hit_b), 64'(eh));
    chk("fwd_data_b", 64'(fwd_data_b), 64'(ed));
    acc = v && (mq.size() < DEPTH);
    pop = (mq.size() > 0) && !st;
    @(posedge clk);
    if (pop) begin
      fl_v = 1'b1;
      fl   = mq.pop_front();
    end else begin
      fl_v = 1'b0;
    end
    if (acc && a != 5'd0) begin
      e.a = a;
      e.d = d;
      mq.push_back(e);
      sb_q.push_back(e);
    end
    #1;
    chk("wr_active", 64'(wr_en != 32'h0), 64'(pop));
    @(negedge clk);
  endtask

  // Monitor: every write the DUT presents must be the next accepted request.
  always @(negedge clk) begin
    ent_t e;
    if (!rst && wr_en != 32'h0) begin
      if (sb_q.size() == 0) begin
        chk("wr_unexpected", 64'(wr_en), 64'h0);
      end else begin
        e = sb_q.pop_front();
        chk("sb_wr_en", 64'(wr_en), 64'(32'h1 << e.a));
        chk("sb_wr_data", 64'(wr_data), 64'(e.d));
      end
    end
  end

  initial begin
    tests = 0;
    fails = 0;
    fl_v = 1'b0;
    fl = '0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_addr = 5'd0;
    in_data = 32'h0;
    drain_stall = 1'b0;
    rd_addr_a = 5'd0;
    rd_addr_b = 5'd0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("reset_level", 64'(level), 64'h0);
    chk("reset_wr_en", 64'(wr_en), 64'h0);
    chk("reset_wr_data", 64'(wr_data), 64'h0);
    chk("reset_in_ready", 64'(in_ready), 64'h1);
    rst = 1'b0;

    // Push into empty queue: write appears one edge after acceptance
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd5, 5'd0);
    chk("lat_wr_en_early", 64'(wr_en), 64'h0);
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 5'd1);
    chk("lat_wr_en", 64'(wr_en), 64'h0000_0020);
    chk("lat_wr_data", 64'(wr_data), 64'hDEADBEEF);
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 5'd0);
    chk("lat_one_cycle", 64'(wr_en), 64'h0);

    // Stalled fill, refused 5th push, ordered drain
    for (int k = 1; k <= 4; k++) step(1'b1, 5'(k), 32'h100 + 32'(k), 1'b1, 5'(k), 5'd2);
    chk("full_level", 64'(level), 64'h4);
    chk("full_in_ready", 64'(in_ready), 64'h0);
    step(1'b1, 5'd9, 32'hBAD, 1'b1, 5'd9, 5'd4);
    for (int k = 1; k <= 4; k++) begin
      step(1'b0, 5'd0, 32'h0, 1'b0, 5'd4, 5'd1);
      chk("drain_wr_en", 64'(wr_en), 64'(32'h1 << k));
    end
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
    chk("drain_done", 64'(wr_en), 64'h0);

    // Forwarding with two writes to one register
    step(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 5'd0);
    step(1'b1, 5'd3, 32'h22, 1'b1, 5'd3, 5'd0);
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd3, 5'd3);
    chk("fwd_young_hit", 64'(fwd_hit_a), 64'h1);
    chk("fwd_young_data", 64'(fwd_data_a), 64'h22);
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd3, 5'd3);
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd3, 5'd3);
    chk("fwd_drained_hit", 64'(fwd_hit_a), 64'h0);

    // Register 0 request is dropped
    step(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 5'd0);
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
    chk("r0_level", 64'(level), 64'h0);
    chk("r0_wr_en", 64'(wr_en), 64'h0);
    chk("r0_fwd_hit", 64'(fwd_hit_a), 64'h0);

    // Reset mid-operation with three pending entries
    for (int k = 1; k <= 3; k++) step(1'b1, 5'(k + 10), $urandom, 1'b1, 5'd0, 5'd0);
    chk("rst_pre_level", 64'(level), 64'h3);
    in_valid = 1'b0;
    drain_stall = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_wr_en", 64'(wr_en), 64'h0);
    chk("rst_level", 64'(level), 64'h0);
    chk("rst_wr_data", 64'(wr_data), 64'h0);
    mq.delete();
    sb_q.delete();
    fl_v = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) step(1'b0, 5'd0, 32'h0, 1'b0, 5'(11 + (k % 3)), 5'd12);

    // Continuous push/pop across pointer wrap
    for (int k = 0; k < 20; k++) step(1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));

    // Randomized traffic
    for (int k = 0; k < 300; k++) begin
      step(($urandom_range(0, 9) < 7), 5'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 3) == 0),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    // Drain and confirm nothing is outstanding
    for (int k = 0; k < 8; k++) step(1'b0, 5'd0, 32'h0, 1'b0, 5'($urandom_range(0, 7)), 5'd0);
    chk("sb_empty", 64'(sb_q.size()), 64'h0);
    chk("final_level", 64'(level), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_write_queue.md
WB_WRITE_QUEUE -- requirements
Module: wb_write_queue

Interface
REQ-001 SHALL have parameter DEPTH, 4, number of pending write entries (power of two, 2..16).
REQ-002 SHALL have parameter NREG, 32, number of architectural registers; address width is log2(NREG).
REQ-003 SHALL have parameter WIDTH, 32, data width of each register.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port in_valid  input  1  write-back request valid.
REQ-007 SHALL have port in_addr  input  5  destination register index.
REQ-008 SHALL have port in_data  input  WIDTH  write-back data.
REQ-009 SHALL have port in_ready  output  1  queue can accept a request this cycle.
REQ-010 SHALL have port drain_stall  input  1  hold the head entry; no write issued.
REQ-011 SHALL have port wr_en  output  NREG  one-hot per-register enable to the register array.
REQ-012 SHALL have port wr_data  output  WIDTH  data broadcast to all registers.
REQ-013 SHALL have ports rd_addr_a, rd_addr_b  input  5  read-port addresses to check for forwarding.
REQ-014 SHALL have ports fwd_hit_a, fwd_hit_b  output  1  pending write exists for that address.
REQ-015 SHALL have ports fwd_data_a, fwd_data_b  output  WIDTH  youngest pending data for that address.
REQ-016 SHALL have port level  output  log2(DEPTH)+1  number of queued entries.

Function
REQ-017 SHALL accept a request on a rising edge where in_valid and in_ready are both high.
REQ-018 SHALL drive in_ready = (level < DEPTH), combinationally from registered state; a full queue refuses even on a same-cycle pop.
REQ-019 SHALL accept requests with in_addr = 0 without enqueueing them (register 0 is never written).
REQ-020 SHALL, on each rising edge with level > 0 and drain_stall low, pop the head entry and register wr_en = one-hot(head addr) and wr_data = head data for exactly one cycle.
REQ-021 SHALL register wr_en = all zeros on any edge without a pop; wr_data holds its last value.
REQ-022 SHALL have latency 1 edge from acceptance into an empty queue to wr_en asserted, so the negative-edge-capturing register array stores the value half a cycle later.
REQ-023 SHALL support simultaneous push and pop when not full; level is unchanged in that case.
REQ-024 SHALL preserve strict FIFO order, including repeated writes to the same address.
REQ-025 SHALL wrap head/tail pointers modulo DEPTH.
REQ-026 SHALL compute forwarding combinationally over all queued entries plus the in-flight output entry (wr_en non-zero); the youngest match wins, and the output entry is oldest.
REQ-027 SHALL never assert fwd_hit for read address 0; fwd_data SHALL be 0 when there is no hit.
REQ-028 SHALL NOT forward the request being accepted in the current cycle.

Reset
REQ-029 SHALL, on rst high, immediately clear level, head and tail pointers, wr_en (all zeros) and wr_data (0), independent of clk.
REQ-030 SHALL discard all pending entries on reset mid-operation; none are written afterwards.
REQ-031 SHALL drive in_ready high in the first cycle after rst deasserts.

Structure
REQ-032 SHALL take NREG, WIDTH and the address-width constant from the shared regfile package, alongside a one-hot decode function.
REQ-033 SHALL isolate the youngest-match priority search in one sub-module, wbq_fwd_match, instantiated once per read port.
REQ-034 SHALL keep the storage as a flat register array with no memory macro.

Verification
REQ-035 SHALL cover: push (addr 5, 0xDEADBEEF) into an empty queue -> the next edge gives wr_en = 0x00000020 and wr_data = 0xDEADBEEF for one cycle.
REQ-036 SHALL cover: drain_stall high, push 4 entries -> level = 4 and in_ready = 0; a 5th push is refused; release the stall -> 4 writes issue in order on consecutive cycles.
REQ-037 SHALL cover: queue (3, 0x11) then (3, 0x22), rd_addr_a = 3 -> fwd_hit_a = 1 and fwd_data_a = 0x22; after both drain, fwd_hit_a = 0.
REQ-038 SHALL cover: push (0, 0xFFFF) -> level stays 0, wr_en stays 0, and fwd_hit for addr 0 stays 0.
REQ-039 SHALL cover: rst asserted mid-clock with level = 3 -> wr_en = 0 and level = 0 before the next edge; no writes issue after release.
REQ-040 SHALL cover: continuous push/pop for 20 cycles through pointer wrap -> the wr_en/wr_data sequence equals the input sequence exactly.
